// File: rtl/insn_fetcher.sv
// Instruction fetch stage: owns the fetch PC, fetches words from instruction
// memory over req/ack, buffers {word, pc} in a small FIFO and hands them to
// the executor over valid/ready. Branch redirects flush the FIFO and discard
// any in-flight fetch.
module insn_fetcher #(
    parameter int unsigned          PC_WIDTH   = 16,
    parameter int unsigned          INSN_WIDTH = 40,
    parameter logic [PC_WIDTH-1:0]  RESET_PC   = '0,
    parameter int unsigned          QDEPTH     = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    output logic                  imem_req,
    output logic [PC_WIDTH-1:0]   imem_addr,
    input  logic                  imem_ack,
    input  logic [INSN_WIDTH-1:0] imem_rdata,
    output logic                  insn_valid,
    output logic [INSN_WIDTH-1:0] insn,
    output logic [PC_WIDTH-1:0]   insn_pc,
    input  logic                  insn_ready,
    input  logic                  redirect_valid,
    input  logic [PC_WIDTH-1:0]   redirect_pc
);

    localparam int unsigned PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t                state, state_nxt;
    logic                  req_nxt;
    logic [PC_WIDTH-1:0]   addr_nxt;
    logic [PC_WIDTH-1:0]   fetch_pc, fetch_pc_nxt;
    logic [PC_WIDTH-1:0]   addr_plus1;

    logic [INSN_WIDTH-1:0] q_insn [QDEPTH];
    logic [PC_WIDTH-1:0]   q_pc   [QDEPTH];
    logic [PTR_W-1:0]      rd_ptr, wr_ptr;
    logic [CNT_W-1:0]      count;

    logic                  pop;
    logic                  push;
    logic                  slot_free;
    logic                  slot_after_push;

    // Head of the FIFO drives the executor interface.
    assign insn_valid = (count != '0);
    assign insn       = q_insn[rd_ptr];
    assign insn_pc    = q_pc[rd_ptr];

    // A redirect suppresses consumption; the flushed head is never executed.
    assign pop        = insn_valid && insn_ready && !redirect_valid;
    assign addr_plus1 = imem_addr + PC_WIDTH'(1);

    // Slot reservation: a request is only issued when its data will fit.
    assign slot_free       = (count - CNT_W'(pop)) < CNT_W'(QDEPTH);
    assign slot_after_push = (count + CNT_W'(1) - CNT_W'(pop)) < CNT_W'(QDEPTH);

    // Fetch state register and registered memory-side outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            imem_req  <= 1'b0;
            imem_addr <= RESET_PC;
            fetch_pc  <= RESET_PC;
        end else begin
            state     <= state_nxt;
            imem_req  <= req_nxt;
            imem_addr <= addr_nxt;
            fetch_pc  <= fetch_pc_nxt;
        end
    end

    // Next-state, next request and push decision; redirect takes priority.
    always_comb begin
        state_nxt    = state;
        req_nxt      = imem_req;
        addr_nxt     = imem_addr;
        fetch_pc_nxt = fetch_pc;
        push         = 1'b0;
        case (state)
            IDLE: begin
                if (redirect_valid) begin
                    req_nxt      = 1'b1;
                    addr_nxt     = redirect_pc;
                    fetch_pc_nxt = redirect_pc;
                    state_nxt    = WAIT;
                end else if (slot_free) begin
                    req_nxt   = 1'b1;
                    addr_nxt  = fetch_pc;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (redirect_valid) begin
                    fetch_pc_nxt = redirect_pc;
                    if (imem_ack) begin
                        // Acked word belongs to the old path; refetch at target.
                        addr_nxt  = redirect_pc;
                        state_nxt = WAIT;
                    end else begin
                        // Request cannot be withdrawn; let it finish and drop it.
                        state_nxt = DROP;
                    end
                end else if (imem_ack) begin
                    push         = 1'b1;
                    fetch_pc_nxt = addr_plus1;
                    if (slot_after_push) begin
                        addr_nxt = addr_plus1;
                    end else begin
                        req_nxt   = 1'b0;
                        state_nxt = IDLE;
                    end
                end
            end
            DROP: begin
                if (redirect_valid) begin
                    fetch_pc_nxt = redirect_pc;
                    if (imem_ack) begin
                        addr_nxt  = redirect_pc;
                        state_nxt = WAIT;
                    end
                end else if (imem_ack) begin
                    addr_nxt  = fetch_pc;
                    state_nxt = WAIT;
                end
            end
            default: begin
                req_nxt   = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    // Instruction FIFO: flush on redirect, otherwise push/pop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < QDEPTH; i++) begin
                q_insn[i] <= '0;
                q_pc[i]   <= '0;
            end
        end else if (redirect_valid) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                q_insn[wr_ptr] <= imem_rdata;
                q_pc[wr_ptr]   <= imem_addr;
                wr_ptr         <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

endmodule
